// File: rtl/serial_transmitter_param.sv
// serial_transmitter_param
//   Parametrised frame serialiser. On an accepted start the parallel word is
//   sent LSB first as: wake-up preamble, start bit, DATA_W data bits,
//   optional parity bit and STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT
//   clocks. While idle the line forwards serial_in with one cycle of latency
//   so an upstream node can share the link.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   serial_in  in   upstream serial line, forwarded while idle
//   start      in   request to send parinp (only honoured while ready=1)
//   parinp     in   DATA_W-bit word to transmit
//   serial_out out  registered serial line
//   wake_em_up out  registered, high for the whole preamble
//   ready      out  registered, high when idle and able to accept start
//   frame_done out  one-cycle pulse in the last clock of the last stop bit
module serial_transmitter_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int WAKE_BITS    = 2,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              start,
  input  logic [DATA_W-1:0] parinp,
  output logic              serial_out,
  output logic              wake_em_up,
  output logic              ready,
  output logic              frame_done
);

  localparam int MAX_DW   = (DATA_W > WAKE_BITS) ? DATA_W : WAKE_BITS;
  localparam int MAX_BITS = (MAX_DW > STOP_BITS) ? MAX_DW : STOP_BITS;
  localparam int BIT_W    = $clog2(MAX_BITS + 1);
  localparam int CYC_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAKE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_sh;
  logic              par_bit;
  logic              last_cyc;

  assign shreg_sh = shreg >> 1;
  assign last_cyc = (int'(cyc_cnt) == CLKS_PER_BIT - 1);

  // Outputs are registered, so every transition loads the line level of the
  // bit period being entered. frame_done is raised one edge early so that it
  // is high exactly during the final clock of the last stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      cyc_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      serial_out <= 1'b1;
      wake_em_up <= 1'b0;
      ready      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          serial_out <= serial_in;
          ready      <= 1'b1;
          if (start) begin
            shreg   <= parinp;
            par_bit <= (^parinp) ^ (PARITY_ODD != 0);
            bit_cnt <= '0;
            cyc_cnt <= '0;
            ready   <= 1'b0;
            if (WAKE_BITS > 0) begin
              state      <= S_WAKE;
              serial_out <= 1'b1;
              wake_em_up <= 1'b1;
            end else begin
              state      <= S_START;
              serial_out <= 1'b0;
            end
          end
        end

        default: begin
          if (!last_cyc) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (state == S_STOP && int'(bit_cnt) == STOP_BITS - 1 &&
                int'(cyc_cnt) == CLKS_PER_BIT - 2)
              frame_done <= 1'b1;
          end else begin
            // bit period boundary
            cyc_cnt <= '0;
            case (state)
              S_WAKE: begin
                if (int'(bit_cnt) == WAKE_BITS - 1) begin
                  bit_cnt    <= '0;
                  state      <= S_START;
                  serial_out <= 1'b0;
                  wake_em_up <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end

              S_START: begin
                bit_cnt    <= '0;
                state      <= S_DATA;
                serial_out <= shreg[0];
              end

              S_DATA: begin
                if (int'(bit_cnt) == DATA_W - 1) begin
                  bit_cnt <= '0;
                  if (PARITY_EN != 0) begin
                    state      <= S_PARITY;
                    serial_out <= par_bit;
                  end else begin
                    state      <= S_STOP;
                    serial_out <= 1'b1;
                    frame_done <= (CLKS_PER_BIT == 1) && (STOP_BITS == 1);
                  end
                end else begin
                  bit_cnt    <= bit_cnt + 1'b1;
                  shreg      <= shreg_sh;
                  serial_out <= shreg_sh[0];
                end
              end

              S_PARITY: begin
                bit_cnt    <= '0;
                state      <= S_STOP;
                serial_out <= 1'b1;
                frame_done <= (CLKS_PER_BIT == 1) && (STOP_BITS == 1);
              end

              S_STOP: begin
                if (int'(bit_cnt) == STOP_BITS - 1) begin
                  bit_cnt    <= '0;
                  state      <= S_IDLE;
                  ready      <= 1'b1;
                  serial_out <= serial_in;
                end else begin
                  bit_cnt    <= bit_cnt + 1'b1;
                  frame_done <= (CLKS_PER_BIT == 1) &&
                                (int'(bit_cnt) + 1 == STOP_BITS - 1);
                end
              end

              default: begin
                state      <= S_IDLE;
                ready      <= 1'b1;
                wake_em_up <= 1'b0;
                serial_out <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_transmitter_param.sv
// tb_serial_transmitter_param
//   Three instances of serial_transmitter_param with different parameter sets
//   (defaults; odd parity / 4 clocks per bit / 2 stop bits; minimal 4-bit
//   frame without preamble or parity). Each instance has a driver that pushes
//   the words it expects to be transmitted into a queue, and a monitor that
//   pops a word whenever the DUT starts a frame and checks every cycle of it
//   against a reference model computed from the frame layout.
module tb_serial_transmitter_param;

  logic clk;
  int   total = 0;
  int   bad   = 0;
  int   n_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int cfg_i, input string what, input int idx,
                     input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL cfg%0d %s idx=%0d got=%h want=%h", cfg_i, what, idx, act, exp_v);
    end
  endtask

  task automatic mark_done();
    n_done++;
  endtask

  // Line level of cycle k of a frame carrying word w, from the frame layout.
  function automatic logic exp_line(input int k, input logic [31:0] w,
                                    input int dw, input int cpb, input int wake,
                                    input int pen, input int podd);
    int   b;
    logic p;
    b = k / cpb;
    if (b < wake) return 1'b1;
    b = b - wake;
    if (b == 0) return 1'b0;
    b = b - 1;
    if (b < dw) return w[b];
    b = b - dw;
    if (pen != 0 && b == 0) begin
      p = (podd != 0);
      for (int i = 0; i < dw; i++) p = p ^ w[i];
      return p;
    end
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int DW   = (g == 2) ? 4 : 8;
    localparam int CPB  = (g == 1) ? 4 : 1;
    localparam int WK   = (g == 2) ? 0 : 2;
    localparam int PEN  = (g == 2) ? 0 : 1;
    localparam int PODD = (g == 1) ? 1 : 0;
    localparam int STP  = (g == 1) ? 2 : 1;
    localparam int LEN  = CPB * (WK + 1 + DW + PEN + STP);
    localparam logic [31:0] D0 = (g == 2) ? 32'hA : ((g == 1) ? 32'h07 : 32'h06);

    logic          rst;
    logic          serial_in;
    logic          start;
    logic [DW-1:0] parinp;
    logic          serial_out;
    logic          wake;
    logic          ready;
    logic          fd;
    logic [31:0]   expq[$];

    serial_transmitter_param #(
      .DATA_W(DW), .CLKS_PER_BIT(CPB), .WAKE_BITS(WK),
      .PARITY_EN(PEN), .PARITY_ODD(PODD), .STOP_BITS(STP)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .serial_in (serial_in),
      .start     (start),
      .parinp    (parinp),
      .serial_out(serial_out),
      .wake_em_up(wake),
      .ready     (ready),
      .frame_done(fd)
    );

    // Upstream line noise, changed just after each falling edge.
    initial begin
      serial_in = 1'b1;
      forever begin
        @(negedge clk);
        #1;
        serial_in = 1'($urandom_range(0, 1));
      end
    end

    // Single accepted frame; optionally pokes start mid-frame and in the
    // final frame cycle, both of which must be ignored.
    task automatic send_one(input logic [DW-1:0] w, input int gap, input bit poke);
      start  = 1'b1;
      parinp = w;
      expq.push_back(32'(w));
      @(negedge clk);
      for (int c = 1; c <= LEN; c++) begin
        if (poke && (c == LEN / 2 || c == LEN)) begin
          start  = 1'b1;
          parinp = '1;
        end else begin
          start  = 1'b0;
          parinp = DW'($urandom);
        end
        @(negedge clk);
      end
      start = 1'b0;
      repeat (gap) @(negedge clk);
    endtask

    // start held high: one frame per LEN+1 cycles, parinp sampled each time.
    task automatic b2b(input int n);
      logic [DW-1:0] w;
      start = 1'b1;
      for (int i = 0; i < n; i++) begin
        w      = DW'($urandom);
        parinp = w;
        expq.push_back(32'(w));
        @(negedge clk);
        for (int c = 1; c <= LEN; c++) begin
          parinp = DW'($urandom);
          @(negedge clk);
        end
      end
      start = 1'b0;
    endtask

    initial begin : drv
      rst    = 1'b1;
      start  = 1'b0;
      parinp = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      send_one(DW'(D0), 2, 1'b1);
      for (int i = 0; i < 4; i++)
        send_one(DW'($urandom), int'($urandom_range(0, 3)), i[0]);
      b2b(4);
      repeat (2) @(negedge clk);
      // reset while in the data bits
      start  = 1'b1;
      parinp = DW'($urandom);
      expq.push_back(32'(parinp));
      @(negedge clk);
      start = 1'b0;
      repeat (CPB * (WK + 3)) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      send_one(DW'($urandom), 1, 1'b0);
      // reset wins over start
      rst    = 1'b1;
      start  = 1'b1;
      parinp = DW'($urandom);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat (4) @(negedge clk);
      send_one(DW'(D0), 3, 1'b0);
      chk(g, "queue_left", 0, 32'(expq.size()), 32'h0);
      mark_done();
    end

    initial begin : mon
      logic        si_s;
      logic        rst_s;
      bit          in_frame;
      int          k;
      logic [31:0] w;
      logic [3:0]  got;
      logic [3:0]  want;
      in_frame = 1'b0;
      k = 0;
      w = '0;
      forever begin
        @(posedge clk);
        si_s  = serial_in;
        rst_s = rst;
        @(negedge clk);
        got = {serial_out, wake, fd, ready};
        if (rst_s) begin
          chk(g, "reset", k, 32'(got), 32'h9);
          in_frame = 1'b0;
        end else if (!in_frame) begin
          if (ready === 1'b0) begin
            if (expq.size() == 0) begin
              chk(g, "unexpected_frame", 0, 32'(ready), 32'h1);
            end else begin
              w = expq.pop_front();
              in_frame = 1'b1;
              k = 0;
            end
          end else begin
            chk(g, "idle_fwd", 0, 32'(got), 32'({si_s, 1'b0, 1'b0, 1'b1}));
          end
        end
        if (in_frame) begin
          want = {exp_line(k, w, DW, CPB, WK, PEN, PODD),
                  1'((k / CPB) < WK), 1'(k == LEN - 1), 1'b0};
          chk(g, "frame", k, 32'(got), 32'(want));
          k++;
          if (k == LEN) in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    wait (n_done == 3);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog time=%0t done=%0d want=3", $time, n_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
